chroma_key_mixer: RTL and testbench

Background chroma-key compositor sitting directly downstream of the 5×5 smoothing stage in the VGA video path. Takes the smoothed RGB444 foreground stream, classifies each pixel as key (green screen) or subject, and substitutes the background pixel for key pixels. Also re-aligns raw display timing to the smoothing-stage latency and reports a per-frame key-pixel count for auto-threshold software.

---
 rtl/chroma_pkg.sv | 30 +++
 rtl/chroma_key_mixer_sync_delay.sv | 31 +++
 rtl/chroma_key_mixer.sv | 146 ++++++++++++++
 tb/tb_chroma_key_mixer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// Shared types, default geometry and pixel helpers for the chroma-key mixer.
// Green spill suppression is compiled in only when CHROMA_SPILL_EN is defined.
package chroma_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int KEY_CNT_W    = 19;

  // Sums are widened to 5 bits so R+margin and B+margin never wrap.
  function automatic logic is_key_px(rgb444_t p, logic [3:0] g_min, logic [3:0] margin);
    logic [4:0] g5;
    g5 = {1'b0, p.g};
    return (p.g >= g_min) &&
           (g5 >= ({1'b0, p.r} + {1'b0, margin})) &&
           (g5 >= ({1'b0, p.b} + {1'b0, margin}));
  endfunction

  function automatic logic [3:0] spill_green(rgb444_t p);
    logic [3:0] mx;
    mx = (p.r > p.b) ? p.r : p.b;
    return (p.g > mx) ? mx : p.g;
  endfunction

endpackage

// File: rtl/chroma_key_mixer_sync_delay.sv
// sync_delay: fixed-depth shift register used to line raw display timing up
// with the smoothed pixel stream. DEPTH must be at least 1.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/chroma_key_mixer.sv
// Chroma-key compositor: keys green foreground pixels to the background and
// reports per-frame key counts. Define CHROMA_SPILL_EN for green spill suppression.
module chroma_key_mixer
  import chroma_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int ALIGN_DLY = 2,
  parameter int MIN_RUN   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 display_enable,
  input  logic [9:0]           x_pixel,
  input  logic [8:0]           y_pixel,
  input  logic [11:0]          pixel_in,
  input  logic [11:0]          bg_pixel,
  input  logic [3:0]           g_min,
  input  logic [3:0]           margin,
  output logic [11:0]          pixel_out,
  output logic                 de_out,
  output logic                 mask_out,
  output logic [KEY_CNT_W-1:0] key_count,
  output logic                 key_count_valid
);

  localparam int TW = 1 + 10 + 9;

  logic [TW-1:0] tim_a;
  logic          de_a;
  logic [9:0]    x_a;
  logic [8:0]    y_a;

  sync_delay #(.WIDTH(TW), .DEPTH(ALIGN_DLY)) u_align (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({display_enable, x_pixel, y_pixel}),
    .q       (tim_a)
  );

  assign de_a = tim_a[19];
  assign x_a  = tim_a[18:9];
  assign y_a  = tim_a[8:0];

  // Stage 1: classification
  rgb444_t fg1_q, fg1_d, bg1_q, bg1_d;
  logic    de1_q, de1_d, key1_q, key1_d;
  logic [9:0] x1_q, x1_d;
  logic [8:0] y1_q, y1_d;

  // Run counter and stage 2: mux
  logic [2:0] run_q, run_d, run_base;
  logic [3:0] run_sum;
  logic       mask;
  rgb444_t    fg_out;
  logic [11:0] pix2_q, pix2_d;
  logic       de2_q, de2_d, mask2_q, mask2_d;
  logic [9:0] x2_q, x2_d;
  logic [8:0] y2_q, y2_d;

  // Frame statistics
  logic                 frame_start, frame_end;
  logic [KEY_CNT_W-1:0] acc_q, acc_d, acc_sum, kc_q, kc_d;
  logic                 armed_q, armed_d, kcv_q, kcv_d;

  always_comb begin
    fg1_d  = rgb444_t'(pixel_in);
    bg1_d  = rgb444_t'(bg_pixel);
    de1_d  = de_a;
    x1_d   = x_a;
    y1_d   = y_a;
    key1_d = de_a && is_key_px(rgb444_t'(pixel_in), g_min, margin);

    // A run restarts at every line start and after any blanking gap.
    run_base = (!de1_q || x1_q == 10'd0) ? 3'd0 : run_q;
    run_sum  = {1'b0, run_base} + 4'd1;
    mask     = key1_q && (run_sum >= 4'(MIN_RUN));
    if (!key1_q)                      run_d = 3'd0;
    else if (run_sum >= 4'(MIN_RUN))  run_d = 3'(MIN_RUN);
    else                              run_d = run_sum[2:0];

    fg_out = fg1_q;
`ifdef CHROMA_SPILL_EN
    fg_out.g = spill_green(fg1_q);
`endif
    de2_d   = de1_q;
    mask2_d = de1_q && mask;
    pix2_d  = !de1_q ? 12'd0 : (mask ? bg1_q : fg_out);
    x2_d    = x1_q;
    y2_d    = y1_q;

    frame_start = de2_q && (x2_q == 10'd0) && (y2_q == 9'd0);
    frame_end   = de2_q && (x2_q == 10'(H_ACTIVE - 1)) && (y2_q == 9'(V_ACTIVE - 1));
    acc_sum     = acc_q + KEY_CNT_W'(mask2_q);
    acc_d       = frame_end ? '0 : acc_sum;
    armed_d     = armed_q || frame_start;
    // An unarmed frame (started before reset released) is never reported.
    kcv_d       = frame_end && armed_q;
    kc_d        = kcv_d ? acc_sum : kc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fg1_q   <= '0;
      bg1_q   <= '0;
      de1_q   <= 1'b0;
      key1_q  <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      run_q   <= '0;
      pix2_q  <= '0;
      de2_q   <= 1'b0;
      mask2_q <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
      acc_q   <= '0;
      kc_q    <= '0;
      armed_q <= 1'b0;
      kcv_q   <= 1'b0;
    end else begin
      fg1_q   <= fg1_d;
      bg1_q   <= bg1_d;
      de1_q   <= de1_d;
      key1_q  <= key1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      run_q   <= run_d;
      pix2_q  <= pix2_d;
      de2_q   <= de2_d;
      mask2_q <= mask2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      acc_q   <= acc_d;
      kc_q    <= kc_d;
      armed_q <= armed_d;
      kcv_q   <= kcv_d;
    end
  end

  assign pixel_out       = pix2_q;
  assign de_out          = de2_q;
  assign mask_out        = mask2_q;
  assign key_count       = kc_q;
  assign key_count_valid = kcv_q;

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Directed bench for chroma_key_mixer on a reduced 16x6 frame; expected outputs
// come from a per-pixel reference model feeding an expected queue.
module tb_chroma_key_mixer;

  localparam int H = 16;
  localparam int V = 6;
  localparam int A = 2;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        display_enable = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [8:0]  y_pixel = '0;
  logic [11:0] pixel_in = '0;
  logic [11:0] bg_pixel = '0;
  logic [3:0]  g_min = 4'd8;
  logic [3:0]  margin = 4'd4;
  logic [11:0] pixel_out;
  logic        de_out;
  logic        mask_out;
  logic [18:0] key_count;
  logic        key_count_valid;

  chroma_key_mixer #(.H_ACTIVE(H), .V_ACTIVE(V), .ALIGN_DLY(A), .MIN_RUN(MR)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .display_enable  (display_enable),
    .x_pixel         (x_pixel),
    .y_pixel         (y_pixel),
    .pixel_in        (pixel_in),
    .bg_pixel        (bg_pixel),
    .g_min           (g_min),
    .margin          (margin),
    .pixel_out       (pixel_out),
    .de_out          (de_out),
    .mask_out        (mask_out),
    .key_count       (key_count),
    .key_count_valid (key_count_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Record layout: [33] pulse, [32:14] key_count, [13] de, [12] mask, [11:0] pixel
  logic [33:0] exp_q[$];
  logic [33:0] prev_rec;
  logic [18:0] exp_kc_cur;

  logic        h_de [A];
  logic [9:0]  h_x  [A];
  logic [8:0]  h_y  [A];
  logic [11:0] h_fg [A];
  logic [11:0] h_bg [A];

  int          m_run;
  bit          m_armed;
  int          m_acc;
  logic [18:0] m_kc;

  logic [11:0] pool [6] = '{12'h0F0, 12'h8A8, 12'h8C8, 12'h2E1, 12'h444, 12'h3F9};

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] fg_model(input logic [11:0] p);
    logic [3:0] r, g, b;
    r = p[11:8]; g = p[7:4]; b = p[3:0];
`ifdef CHROMA_SPILL_EN
    begin
      logic [3:0] mx;
      mx = (r > b) ? r : b;
      if (g > mx) g = mx;
    end
`endif
    return {r, g, b};
  endfunction

  task automatic model_pixel(input logic de, input logic [9:0] x, input logic [8:0] y,
                             input logic [11:0] fg, input logic [11:0] bg);
    int r, g, b, base;
    bit is_key, mask, pulse;
    logic [11:0] pix;
    r = int'(fg[11:8]); g = int'(fg[7:4]); b = int'(fg[3:0]);
    is_key = de && (g >= int'(g_min)) && (g >= r + int'(margin)) && (g >= b + int'(margin));
    base = (!de || x == 10'd0) ? 0 : m_run;
    mask = is_key && (base + 1 >= MR);
    m_run = !is_key ? 0 : ((base + 1 > MR) ? MR : base + 1);
    pix = !de ? 12'h000 : (mask ? bg : fg_model(fg));
    pulse = 1'b0;
    if (de && x == 10'd0 && y == 9'd0) m_armed = 1'b1;
    m_acc += int'(mask);
    if (de && x == 10'(H-1) && y == 9'(V-1)) begin
      if (m_armed) begin
        pulse = 1'b1;
        m_kc  = 19'(m_acc);
      end
      m_acc = 0;
    end
    exp_q.push_back({pulse, m_kc, de, mask, pix});
  endtask

  task automatic check_outputs();
    logic [33:0] rec;
    rec = exp_q.pop_front();
    if (prev_rec[33]) exp_kc_cur = prev_rec[32:14];
    chk("key_count_valid", 34'(key_count_valid), 34'(prev_rec[33]));
    chk("key_count", 34'(key_count), 34'(exp_kc_cur));
    chk("de_out", 34'(de_out), 34'(rec[13]));
    chk("mask_out", 34'(mask_out), 34'(rec[12]));
    chk("pixel_out", 34'(pixel_out), 34'(rec[11:0]));
    prev_rec = rec;
  endtask

  // One pixel clock: raw timing enters now, pixel data of the timing sent A clocks ago.
  task automatic step(input logic de, input logic [9:0] x, input logic [8:0] y,
                      input logic [11:0] fg, input logic [11:0] bg);
    @(negedge clk);
    check_outputs();
    display_enable = de;
    x_pixel        = x;
    y_pixel        = y;
    pixel_in       = h_fg[A-1];
    bg_pixel       = h_bg[A-1];
    model_pixel(h_de[A-1], h_x[A-1], h_y[A-1], h_fg[A-1], h_bg[A-1]);
    for (int i = A - 1; i > 0; i--) begin
      h_de[i] = h_de[i-1]; h_x[i] = h_x[i-1]; h_y[i] = h_y[i-1];
      h_fg[i] = h_fg[i-1]; h_bg[i] = h_bg[i-1];
    end
    h_de[0] = de; h_x[0] = x; h_y[0] = y; h_fg[0] = fg; h_bg[0] = bg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pixel_out", 34'(pixel_out), 34'd0);
    chk("rst_de_out", 34'(de_out), 34'd0);
    chk("rst_mask_out", 34'(mask_out), 34'd0);
    chk("rst_key_count", 34'(key_count), 34'd0);
    chk("rst_kcv", 34'(key_count_valid), 34'd0);
    @(negedge clk);
    @(negedge clk);
    display_enable = 1'b0;
    pixel_in = '0;
    bg_pixel = '0;
    reset_n = 1'b1;
    for (int i = 0; i < A; i++) begin
      h_de[i] = 1'b0; h_x[i] = '0; h_y[i] = '0; h_fg[i] = '0; h_bg[i] = '0;
    end
    m_run = 0; m_armed = 1'b0; m_acc = 0; m_kc = '0;
    prev_rec = '0; exp_kc_cur = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic blank(input int n, input logic [8:0] y);
    for (int i = 0; i < n; i++) step(1'b0, 10'(H + i), y, 12'h0F0, 12'hABC);
  endtask

  task automatic random_line(input logic [8:0] y, input int first_x);
    for (int x = first_x; x < H; x++)
      step(1'b1, 10'(x), y, pool[$urandom_range(0, 5)], 12'($urandom_range(0, 4095)));
    blank(3, y);
  endtask

  initial begin
    do_reset();

    // Short key run mid-line: first pixel foreground, next two background.
    for (int x = 0; x < H; x++)
      step(1'b1, 10'(x), 9'd2, (x >= 5 && x <= 7) ? 12'h0F0 : 12'h444, 12'hABC);
    blank(3, 9'd2);

    // Green excess below margin: never keyed.
    for (int x = 0; x < H; x++) step(1'b1, 10'(x), 9'd3, 12'h8A8, 12'hABC);
    blank(3, 9'd3);

    // Key line broken by a de gap at x=8, then a run crossing into the next line.
    for (int x = 0; x < H; x++) step(x != 8, 10'(x), 9'd4, 12'h0F0, 12'h123);
    blank(3, 9'd4);
    for (int x = 0; x < H; x++) step(1'b1, 10'(x), 9'd5, (x < 4) ? 12'h0F0 : 12'h8C8, 12'h456);
    blank(3, 9'd5);

    // display_enable toggling.
    for (int i = 0; i < 8; i++) step(i[0], 10'(i + 1), 9'd1, 12'h0F0, 12'h789);

    // Armed all-key frame.
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) step(1'b1, 10'(x), 9'(y), 12'h0F0, 12'hABC);
      blank(3, 9'(y));
    end
    blank(3, 9'd0);
    chk("all_key_frame_count", 34'(key_count), 34'((H - 1) * V));

    // Threshold boundary: G equal to g_min is still key.
    g_min = 4'd15;
    for (int x = 0; x < 6; x++) step(1'b1, 10'(x), 9'd1, x[0] ? 12'h0E0 : 12'h0F0, 12'h321);
    blank(4, 9'd1);
    g_min = 4'd8;

    // Random frame interrupted by reset at y=3: must not report.
    for (int y = 0; y < 3; y++) random_line(9'(y), 0);
    for (int x = 0; x < 7; x++) step(1'b1, 10'(x), 9'd3, 12'h0F0, 12'h111);
    do_reset();
    random_line(9'd3, 7);
    for (int y = 4; y < V; y++) random_line(9'(y), 0);

    // Complete random frame after reset.
    for (int y = 0; y < V; y++) random_line(9'(y), 0);
    blank(6, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
